// File: rtl/mem_ctrl.sv
// Byte-serial arbiter/sequencer: one 8-bit synchronous RAM shared by instruction fetch and load/store.
// The MEM stage has strict priority over fetch. Words are assembled little-endian and every output is registered.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cyc_q, cyc_d;
  logic [2:0]        n_q, n_d;
  logic              src_mem_q, src_mem_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_wr_q, ram_wr_d, busy_q, busy_d;
  logic [2:0]        rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      n_q         <= '0;
      src_mem_q   <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_dout_q  <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      n_q         <= n_d;
      src_mem_q   <= src_mem_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_dout_q  <= ram_dout_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      busy_q      <= busy_d;
    end
  end

  // cyc_q is the cycle number inside a transaction; the first non-IDLE cycle is 1.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q + 3'd1;
    n_d       = n_q;
    src_mem_d = src_mem_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        cyc_d = 3'd1;
        if (mem_req) begin
          base_d    = mem_addr;
          wdata_d   = mem_wdata;
          src_mem_d = 1'b1;
          n_d       = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;
          state_d   = mem_we ? WRITE : READ;
        end else if (if_req) begin
          base_d    = if_addr;
          src_mem_d = 1'b0;
          n_d       = 3'd4;
          state_d   = READ;
        end
      end
      READ:    if (cyc_q == n_q + 3'd2) state_d = IDLE;
      WRITE:   if (cyc_q == n_q + 3'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_idx = cyc_q - 3'd2;

  // Computes what the registered outputs show in the next cycle.
  always_comb begin
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;
    buf_d       = buf_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        buf_d = '0;
        if (state_d != IDLE) ram_a_d = base_d;
        if (state_d == WRITE) begin
          ram_wr_d   = 1'b1;
          ram_dout_d = mem_wdata[7:0];
        end
      end
      READ: begin
        if (cyc_q < n_q) ram_a_d = base_q + ADDR_W'(cyc_q);
        if (cyc_q >= 3'd2 && cyc_q <= n_q + 3'd1) begin
          buf_d[{rd_idx[1:0], 3'b000} +: 8] = ram_din;
          if (cyc_q == n_q + 3'd1) begin
            if (src_mem_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = buf_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end
          end
        end
      end
      WRITE: begin
        if (cyc_q < n_q) begin
          ram_a_d    = base_q + ADDR_W'(cyc_q);
          ram_dout_d = wdata_q[{cyc_q[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end
        if (cyc_q == n_q) mem_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_dout  = ram_dout_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a byte RAM model plus a reference memory that predicts
// every bus cycle, done pulse and assembled word from the request alone.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, mem_done, ram_wr, busy;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic [7:0]  ram_din, ram_dout;

  int tests = 0;
  int fails = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write commits at the edge ending the cycle, read data one cycle later.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] = ram_dout;
    ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
  end

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at the start of cycle 0 with the winning request already driven;
  // returns in the done cycle.
  task automatic serve(input bit is_mem, input bit we, input int n,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int d;
    logic [31:0] exp_data;
    d = we ? n + 1 : n + 2;
    exp_data = '0;
    if (!we) for (int i = 0; i < n; i++) exp_data[8*i +: 8] = ref_rd(addr + 32'(i));
    for (int k = 1; k <= d; k++) begin
      @(posedge clk); #1;
      chk("busy", busy, 1);
      if (k <= n) begin
        chk("ram_a", ram_a, addr + 32'(k - 1));
        chk("ram_wr", ram_wr, we);
        if (we) chk("ram_dout", ram_dout, wdata[8*(k-1) +: 8]);
      end else begin
        chk("ram_wr_tail", ram_wr, 0);
      end
      chk(is_mem ? "mem_done" : "if_done", is_mem ? mem_done : if_done, (k == d));
      chk("other_done", is_mem ? if_done : mem_done, 0);
      if (k == d && !we) chk(is_mem ? "mem_rdata" : "if_data", is_mem ? mem_rdata : if_data, exp_data);
    end
    if (we) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
    $display("[TB] %s we=%0d n=%0d addr=%h wdata=%h exp=%h", is_mem ? "MEM" : "IF ",
             we, n, addr, wdata, exp_data);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [1:0]  len_code;
    logic [31:0] a, w;
    bit          m, wr;
    int          n;
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; mem_len = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_done", if_done, 0);  chk("rst_mem_done", mem_done, 0);
    chk("rst_if_data", if_data, 0);  chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_ram_a", ram_a, 0);      chk("rst_ram_dout", ram_dout, 0);
    chk("rst_ram_wr", ram_wr, 0);    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Instruction fetch
    set_byte(32'h1000, 8'h13); set_byte(32'h1001, 8'h05);
    set_byte(32'h1002, 8'h10); set_byte(32'h1003, 8'h00);
    if_addr = 32'h1000; if_req = 1;
    serve(0, 0, 4, 32'h1000, 0);
    if_req = 0;
    idle_cycle();
    chk("t1_if_data", if_data, 32'h00100513);

    // Store word
    mem_req = 1; mem_we = 1; mem_len = 2'b10; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
    serve(1, 1, 4, 32'h20, 32'hDEADBEEF);
    mem_req = 0; mem_we = 0;
    idle_cycle();
    chk("t2_b0", ram_rd(32'h20), 8'hEF); chk("t2_b1", ram_rd(32'h21), 8'hBE);
    chk("t2_b2", ram_rd(32'h22), 8'hAD); chk("t2_b3", ram_rd(32'h23), 8'hDE);

    // Simultaneous requests: load byte wins, fetch follows from IDLE
    set_byte(32'h8, 8'hF0);
    mem_req = 1; mem_len = 2'b00; mem_addr = 32'h8; if_req = 1; if_addr = 32'h1000;
    serve(1, 0, 1, 32'h8, 0);
    chk("t3_rdata", mem_rdata, 32'h000000F0);
    @(posedge clk); #1;
    mem_req = 0;
    chk("t3_busy_idle", busy, 0);
    serve(0, 0, 4, 32'h1000, 0);
    if_req = 0;
    idle_cycle();
    chk("t3_rdata_hold", mem_rdata, 32'h000000F0);

    // Halfword load wrapping through address 0
    set_byte(32'hFFFFFFFF, 8'h34); set_byte(32'h0, 8'h12);
    mem_req = 1; mem_len = 2'b01; mem_addr = 32'hFFFFFFFF;
    serve(1, 0, 2, 32'hFFFFFFFF, 0);
    mem_req = 0;
    idle_cycle();
    chk("t4_rdata", mem_rdata, 32'h00001234);

    // Reset in the middle of a word store
    for (int i = 0; i < 4; i++) set_byte(32'h40 + 32'(i), 8'h11);
    mem_req = 1; mem_we = 1; mem_len = 2'b10; mem_addr = 32'h40; mem_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    chk("t5_wr_c1", ram_wr, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_wr_rst", ram_wr, 0);
    chk("t5_busy_rst", busy, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("t5_no_done", mem_done, 0);
    end
    mem_req = 0; mem_we = 0;
    @(negedge clk); rst = 1'b0;
    ref_mem[32'h40] = 8'hD4;
    chk("t5_b0", ram_rd(32'h40), 8'hD4);
    chk("t5_b1", ram_rd(32'h41), 8'h11);
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h1000;
    serve(0, 0, 4, 32'h1000, 0);
    if_req = 0;
    idle_cycle();

    // Back-to-back fetches: new request presented in the IDLE cycle after done
    if_req = 1; if_addr = 32'h20;
    serve(0, 0, 4, 32'h20, 0);
    @(posedge clk); #1;
    if_addr = 32'h1000;
    chk("t6_busy_idle", busy, 0);
    serve(0, 0, 4, 32'h1000, 0);
    if_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t6_no_double", if_done, 0);
      chk("t6_busy_low", busy, 0);
    end

    // Randomized mix against the reference memory
    for (int i = 0; i < 64; i++) set_byte(32'h100 + 32'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) set_byte(32'hFFFFFFFC + 32'(i), 8'($urandom));
    for (int t = 0; t < 40; t++) begin
      m  = $urandom_range(0, 2) != 0;
      wr = m && ($urandom_range(0, 1) == 1);
      len_code = 2'($urandom_range(0, 3));
      n = !m ? 4 : (len_code == 2'b00) ? 1 : (len_code == 2'b01) ? 2 : 4;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'h100 + 32'($urandom_range(0, 63));
      w = $urandom;
      if (m) begin
        mem_req = 1; mem_we = wr; mem_len = len_code; mem_addr = a; mem_wdata = w;
      end else begin
        if_req = 1; if_addr = a;
      end
      serve(m, wr, n, a, w);
      mem_req = 0; if_req = 0; mem_we = 0;
      idle_cycle();
      if (wr) for (int i = 0; i < n; i++)
        chk("rand_ram", ram_rd(a + 32'(i)), ref_rd(a + 32'(i)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
